// File: rtl/pulse_gate_scheduler.sv
// Round-robin gated pulse counter: one count datapath is time-shared across
// CHANNELS synchronised pulse inputs and each result leaves on valid/ready.
module pulse_gate_scheduler #(
  parameter int unsigned  CHANNELS      = 32'd4,
  parameter int unsigned  GATE_CYCLES   = 32'd200000000,
  parameter int unsigned  SETTLE_CYCLES = 32'd2,
  parameter int unsigned  CNT_WIDTH     = 32'd8,
  localparam int unsigned CW            = $clog2(CHANNELS)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [CHANNELS-1:0]  pulse_in,
  input  logic                 start_in,
  input  logic                 continuous_in,
  input  logic                 result_ready_in,
  output logic                 result_valid_out,
  output logic [CW-1:0]        result_chan_out,
  output logic [CNT_WIDTH-1:0] result_count_out,
  output logic                 result_ovf_out,
  output logic                 gate_out,
  output logic                 busy_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  localparam logic [CW-1:0]        CHAN_LAST   = CW'(CHANNELS - 32'd1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
  localparam logic [31:0]          SETTLE_LAST = 32'(SETTLE_CYCLES - 32'd1);
  localparam logic [31:0]          GATE_LAST   = 32'(GATE_CYCLES - 32'd1);

  logic [CHANNELS-1:0]  sync1_r, sync2_r, sync2_d_r, edge_r;
  state_t               state_r, state_s;
  logic [CW-1:0]        chan_r, chan_s;
  logic [31:0]          timer_r, timer_s;
  logic [CNT_WIDTH-1:0] count_r, count_s, inc_count_s;
  logic                 ovf_r, ovf_s, inc_ovf_s, edge_sel_s;
  logic                 valid_r, valid_s, rovf_r, rovf_s;
  logic [CW-1:0]        rchan_r, rchan_s;
  logic [CNT_WIDTH-1:0] rcount_r, rcount_s;
  logic                 gate_r, gate_s, busy_r, busy_s;

  assign result_valid_out = valid_r;
  assign result_chan_out  = rchan_r;
  assign result_count_out = rcount_r;
  assign result_ovf_out   = rovf_r;
  assign gate_out         = gate_r;
  assign busy_out         = busy_r;

  // Per-channel 2-flop synchroniser followed by a registered rising-edge strobe
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_r   <= {CHANNELS{1'b0}};
      sync2_r   <= {CHANNELS{1'b0}};
      sync2_d_r <= {CHANNELS{1'b0}};
      edge_r    <= {CHANNELS{1'b0}};
    end else begin
      sync1_r   <= pulse_in;
      sync2_r   <= sync1_r;
      sync2_d_r <= sync2_r;
      edge_r    <= sync2_r & ~sync2_d_r;
    end
  end

  // Scheduler state and registered result/status outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r  <= ST_IDLE;
      chan_r   <= {CW{1'b0}};
      timer_r  <= 32'd0;
      count_r  <= {CNT_WIDTH{1'b0}};
      ovf_r    <= 1'b0;
      valid_r  <= 1'b0;
      rchan_r  <= {CW{1'b0}};
      rcount_r <= {CNT_WIDTH{1'b0}};
      rovf_r   <= 1'b0;
      gate_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      chan_r   <= chan_s;
      timer_r  <= timer_s;
      count_r  <= count_s;
      ovf_r    <= ovf_s;
      valid_r  <= valid_s;
      rchan_r  <= rchan_s;
      rcount_r <= rcount_s;
      rovf_r   <= rovf_s;
      gate_r   <= gate_s;
      busy_r   <= busy_s;
    end
  end

  // Next-state, saturating count and result capture
  always_comb begin
    edge_sel_s = edge_r[chan_r];
    if (edge_sel_s && (count_r != CNT_MAX)) begin
      inc_count_s = count_r + CNT_WIDTH'(1'b1);
    end else begin
      inc_count_s = count_r;
    end
    inc_ovf_s = ovf_r | (edge_sel_s & (count_r == CNT_MAX));

    state_s  = state_r;
    chan_s   = chan_r;
    timer_s  = timer_r;
    count_s  = count_r;
    ovf_s    = ovf_r;
    valid_s  = valid_r;
    rchan_s  = rchan_r;
    rcount_s = rcount_r;
    rovf_s   = rovf_r;

    case (state_r)
      ST_IDLE: begin
        if (start_in) begin
          state_s = ST_SETTLE;
          chan_s  = {CW{1'b0}};
          timer_s = 32'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        count_s = {CNT_WIDTH{1'b0}};
        ovf_s   = 1'b0;
        if (timer_r == SETTLE_LAST) begin
          state_s = ST_GATE;
          timer_s = 32'd0;
        end else begin
          timer_s = timer_r + 32'd1;
        end
      end
      ST_GATE: begin
        count_s = inc_count_s;
        ovf_s   = inc_ovf_s;
        if (timer_r == GATE_LAST) begin
          // The last gate cycle's edge is folded straight into the result
          state_s  = ST_REPORT;
          timer_s  = 32'd0;
          valid_s  = 1'b1;
          rchan_s  = chan_r;
          rcount_s = inc_count_s;
          rovf_s   = inc_ovf_s;
        end else begin
          timer_s = timer_r + 32'd1;
        end
      end
      ST_REPORT: begin
        if (valid_r && result_ready_in) begin
          valid_s = 1'b0;
          timer_s = 32'd0;
          if ((chan_r == CHAN_LAST) && !continuous_in) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_SETTLE;
            chan_s  = (chan_r == CHAN_LAST) ? {CW{1'b0}} : chan_r + CW'(1'b1);
          end
        end else begin
          state_s = ST_REPORT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        chan_s  = {CW{1'b0}};
        timer_s = 32'd0;
        valid_s = 1'b0;
      end
    endcase

    gate_s = (state_s == ST_GATE);
    busy_s = (state_s != ST_IDLE);
  end

endmodule

// File: tb/tb_pulse_gate_scheduler.sv
// Randomised scoreboard bench for pulse_gate_scheduler: a window-level model
// predicts each result from the recorded pulse trace and the handshake history.
module tb_pulse_gate_scheduler;

  localparam int CH   = 4;
  localparam int G    = 16;
  localparam int S    = 2;
  localparam int CNTW = 3;
  localparam int CMAX = 7;
  localparam int MAXC = 20000;

  typedef struct {
    int chan;
    int cnt;
    int ovf;
  } exp_t;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic [CH-1:0]   pulse_in;
  logic            start_in;
  logic            continuous_in;
  logic            result_ready_in;
  logic            result_valid_out;
  logic [1:0]      result_chan_out;
  logic [CNTW-1:0] result_count_out;
  logic            result_ovf_out;
  logic            gate_out;
  logic            busy_out;

  int n_checks = 0;
  int n_fail   = 0;
  int n_results = 0;

  logic [CH-1:0] ptrace [MAXC];
  int   cyc = 0;
  int   last_edge = -1;
  int   last_rst = -1;
  int   anchor = 0;
  int   m_chan = 0;
  bit   m_run = 1'b0;
  bit   m_wait = 1'b0;
  bit   exp_valid = 1'b0;
  bit   exp_gate = 1'b0;
  bit   exp_busy = 1'b0;
  bit   mon_en = 1'b0;
  bit   have_cur = 1'b0;
  exp_t cur;
  exp_t sb[$];
  int   pat_mode = 0;

  pulse_gate_scheduler #(
    .CHANNELS(CH), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_WIDTH(CNTW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .pulse_in(pulse_in), .start_in(start_in),
    .continuous_in(continuous_in), .result_ready_in(result_ready_in),
    .result_valid_out(result_valid_out), .result_chan_out(result_chan_out),
    .result_count_out(result_count_out), .result_ovf_out(result_ovf_out),
    .gate_out(gate_out), .busy_out(busy_out)
  );

  initial forever #5 clk_in = ~clk_in;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Pulse level seen at edge k; anything at or before a reset is treated as low
  function automatic bit pv(input int k, input int ch);
    if (k < 0 || k <= last_rst || k >= MAXC) return 1'b0;
    return ptrace[k][ch];
  endfunction

  // Reference: gate window anchored at trigger edge a counts rising edges
  // whose level change reached the pin 3 edges before each update edge.
  task automatic model_step();
    exp_t e;
    if (cyc < MAXC) ptrace[cyc] = pulse_in;
    last_edge = cyc;
    if (rst_in) begin
      m_run = 1'b0; m_wait = 1'b0; last_rst = cyc; sb.delete();
    end else if (!m_run) begin
      if (start_in) begin
        m_run = 1'b1; m_wait = 1'b0; anchor = cyc; m_chan = 0;
      end
    end else if (m_wait) begin
      if (result_ready_in) begin
        m_wait = 1'b0;
        if (m_chan == CH - 1 && !continuous_in) m_run = 1'b0;
        else begin
          m_chan = (m_chan + 1) % CH;
          anchor = cyc;
        end
      end
    end else if (cyc == anchor + S + G) begin
      e.chan = m_chan; e.cnt = 0; e.ovf = 0;
      for (int j = anchor + S + 1; j <= anchor + S + G; j++) begin
        if (pv(j - 3, m_chan) && !pv(j - 4, m_chan)) begin
          if (e.cnt == CMAX) e.ovf = 1;
          else e.cnt++;
        end
      end
      sb.push_back(e);
      m_wait = 1'b1;
    end
    exp_busy  = m_run;
    exp_valid = m_wait;
    exp_gate  = m_run && !m_wait && (cyc >= anchor + S) && (cyc <= anchor + S + G - 1);
    cyc++;
  endtask

  initial forever begin
    @(posedge clk_in);
    model_step();
  end

  // Monitor: status every cycle, result fields whenever valid is shown
  initial forever begin
    @(negedge clk_in);
    if (mon_en) begin
      chk("valid", int'(result_valid_out), int'(exp_valid));
      chk("gate", int'(gate_out), int'(exp_gate));
      chk("busy", int'(busy_out), int'(exp_busy));
      if (result_valid_out && exp_valid) begin
        if (!have_cur) begin
          chk("sb_avail", sb.size(), 1);
          if (sb.size() > 0) begin
            cur = sb.pop_front();
            have_cur = 1'b1;
            n_results++;
          end
        end
        if (have_cur) begin
          chk("res_chan", int'(result_chan_out), cur.chan);
          chk("res_count", int'(result_count_out), cur.cnt);
          chk("res_ovf", int'(result_ovf_out), cur.ovf);
        end
      end else if (!result_valid_out) begin
        have_cur = 1'b0;
      end
    end
  end

  // Pulse pattern generator
  initial forever begin
    logic [CH-1:0] p;
    @(negedge clk_in);
    p = 4'b0000;
    case (pat_mode)
      0: p[1] = (cyc % 4 == 0);
      1: p[2] = (cyc % 2 == 1);
      2: p[0] = 1'b1;
      3: p = 4'($urandom_range(0, 15));
      default: p = 4'b0000;
    endcase
    pulse_in = p;
  end

  task automatic do_start();
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy_out && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    chk({name, "_idle"}, int'(busy_out), 0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, int'(result_valid_out), 0);
    chk({name, "_chan"}, int'(result_chan_out), 0);
    chk({name, "_count"}, int'(result_count_out), 0);
    chk({name, "_ovf"}, int'(result_ovf_out), 0);
    chk({name, "_gate"}, int'(gate_out), 0);
    chk({name, "_busy"}, int'(busy_out), 0);
  endtask

  initial begin
    int base, n;
    int hold_chan, hold_cnt, hold_ovf;
    rst_in = 1'b1; start_in = 1'b0; continuous_in = 1'b0;
    result_ready_in = 1'b1; pulse_in = 4'b0000;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    chk_all_zero("reset");
    mon_en = 1'b1;

    // Basic one-shot scan, pulse on channel 1 every 4 cycles
    pat_mode = 0;
    repeat (2) @(negedge clk_in);
    base = n_results;
    do_start();
    wait_idle("basic", 200);
    chk("basic_nres", n_results - base, 4);

    // Saturation on channel 2
    pat_mode = 1;
    repeat (2) @(negedge clk_in);
    base = n_results;
    do_start();
    wait_idle("sat", 200);
    chk("sat_nres", n_results - base, 4);

    // Level held high before start counts nothing on channel 0
    pat_mode = 2;
    repeat (6) @(negedge clk_in);
    do_start();
    wait_idle("hold", 200);

    // Backpressure on the channel 0 result
    pat_mode = 0;
    result_ready_in = 1'b0;
    repeat (2) @(negedge clk_in);
    do_start();
    n = 0;
    while (!result_valid_out && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    chk("bp_valid_seen", int'(result_valid_out), 1);
    hold_chan = int'(result_chan_out);
    hold_cnt  = int'(result_count_out);
    hold_ovf  = int'(result_ovf_out);
    repeat (10) @(negedge clk_in);
    chk("bp_valid_held", int'(result_valid_out), 1);
    chk("bp_chan_held", int'(result_chan_out), hold_chan);
    chk("bp_count_held", int'(result_count_out), hold_cnt);
    chk("bp_ovf_held", int'(result_ovf_out), hold_ovf);
    chk("bp_gate_low", int'(gate_out), 0);
    result_ready_in = 1'b1;
    @(negedge clk_in);
    chk("bp_valid_drop", int'(result_valid_out), 0);
    chk("bp_busy", int'(busy_out), 1);
    wait_idle("bp", 200);

    // Continuous random scan with random ready and ignored start pulses
    pat_mode = 3;
    continuous_in = 1'b1;
    do_start();
    base = n_results;
    n = 0;
    while (n_results < base + 6 && n < 2000) begin
      start_in = ($urandom_range(0, 7) == 0);
      result_ready_in = ($urandom_range(0, 3) != 0);
      @(negedge clk_in);
      n++;
    end
    start_in = 1'b0;
    chk("cont_wrapped", int'(n_results >= base + 6), 1);
    continuous_in = 1'b0;
    result_ready_in = 1'b1;
    wait_idle("cont", 400);

    // Reset on the 8th gate cycle of channel 1
    do_start();
    n = 0;
    while (!(m_run && !m_wait && m_chan == 1 && last_edge == anchor + S + 7) && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    chk("rst_point_reached", int'(n < 200), 1);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    chk_all_zero("midrst");
    repeat (3) @(negedge clk_in);
    base = n_results;
    do_start();
    wait_idle("post_rst", 300);
    chk("post_rst_nres", n_results - base, 4);

    repeat (3) @(negedge clk_in);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_gate_scheduler.md
Name: pulse_gate_scheduler

Overview:
Time-multiplexes one gated pulse-count datapath across CHANNELS pulse inputs. Each channel is selected round-robin, given a settle window, then counted over a fixed gate window, and the result is presented on a valid/ready handshake to the display/LED path. Sits between raw pulse pins and the segment/LED drivers, replacing per-channel free-running gate counters.

Parameters:
CHANNELS, 4, number of pulse inputs; must be at least 2.
GATE_CYCLES, 200000000, clk_in cycles per gate window; must be at least 1; 32-bit.
SETTLE_CYCLES, 2, cycles discarded after each channel switch; must be at least 1.
CNT_WIDTH, 8, width of the pulse count; the count saturates at 2^CNT_WIDTH-1.
CW, $clog2(CHANNELS), derived channel index width.

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-high
pulse_in  input  CHANNELS  asynchronous pulse inputs, one bit per channel
start_in  input  1  begin a scan; sampled only in IDLE
continuous_in  input  1  1 = rescan forever, 0 = one pass over all channels
result_ready_in  input  1  consumer accepts the result
result_valid_out  output  1  result fields valid
result_chan_out  output  CW  channel index of the result
result_count_out  output  CNT_WIDTH  rising-edge count in the gate window
result_ovf_out  output  1  count saturated
gate_out  output  1  high during GATE cycles
busy_out  output  1  high whenever state is not IDLE

Behaviour:
- Reset: rst_in sampled high at a clock edge puts all outputs to 0, state to IDLE, chan to 0, counters and synchronisers to 0. Reset mid-operation discards any partial count, and no result is emitted.
- Input path: each pulse_in bit goes through a 2-flop synchroniser and then a rising-edge detector (sync2 & ~sync2_d). All channels run continuously. A level held high counts as 0 after its first edge.
- FSM states:
  - IDLE: if start_in is 1, go to SETTLE next cycle with chan = 0.
  - SETTLE: count register is cleared. Stay for exactly SETTLE_CYCLES cycles, then go to GATE.
  - GATE: stay for exactly GATE_CYCLES cycles with gate_out = 1. Each cycle, the edge strobe of channel chan increments the count. An edge on the first or last GATE cycle is counted. Edges in SETTLE, REPORT or IDLE are never counted.
  - REPORT: entered the cycle after the last GATE cycle. On entry, result_valid_out = 1 and the result fields are loaded. The fields are held stable until result_valid_out & result_ready_in. No new gate starts while a result is pending.
  - On handshake: if chan == CHANNELS-1 and continuous_in == 0, go to IDLE. Otherwise go to SETTLE with chan = chan+1, wrapping CHANNELS-1 to 0. continuous_in is sampled on the handshake cycle. result_valid_out drops the cycle after the handshake.
- Arithmetic: the count saturates at 2^CNT_WIDTH-1. result_ovf_out = 1 if an edge arrives while the count is already at max. The gate counter is 32-bit and compares to GATE_CYCLES-1.
- start_in is ignored outside IDLE.
- Latency:
  - start_in seen high at edge t: first SETTLE cycle is t+1, first GATE cycle is t+1+SETTLE_CYCLES, result_valid_out rises at t+1+SETTLE_CYCLES+GATE_CYCLES.
  - Pulse-to-count latency is 3 cycles: 2 synchroniser stages plus the edge register.
- Per-channel period with immediate ready: SETTLE_CYCLES + GATE_CYCLES + 1 cycles.

Test Plan:
- Bench parameters: CHANNELS=4, GATE_CYCLES=16, SETTLE_CYCLES=2, CNT_WIDTH=3.
- Basic count: pulse_in[1] is a 1-cycle high pulse every 4 cycles, ready tied 1, start one-shot -> four results, chan 0,1,2,3, counts 0,4,0,0, ovf 0, then busy_out = 0 and state IDLE.
- Saturation: pulse_in[2] toggles every cycle (8 edges per gate) -> chan 2 result count = 7, ovf = 1; the other channels report count 0, ovf 0.
- Edge-only: pulse_in[0] held high from before start -> chan 0 count = 0.
- Backpressure: result_ready_in low for 10 cycles after valid on chan 0 -> valid stays 1, chan/count/ovf unchanged, gate_out stays 0. Release ready -> valid drops next cycle and chan 1 SETTLE begins.
- Continuous wrap: continuous_in = 1 -> the result after chan 3 is chan 0. Deassert continuous_in before the chan 3 handshake -> IDLE after chan 3 and busy_out = 0. start_in pulsed mid-scan has no effect.
- Reset mid-GATE: rst_in high for 1 cycle on the 8th GATE cycle of chan 1 -> all outputs 0 the next cycle, no result for the partial window. A subsequent start gives the chan 0 result first with the correct count.
